// File: rtl/ziswap_seq_ctrl_if.sv
// rtl/ziswap_seq_ctrl_if.sv - request, data-bus and writeback signals of the Ziswap sequencer (ZISWAP_BUS_LOCK_EN adds mem_lock)
interface ziswap_seq_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_misalign;
    logic        busy;
`ifdef ZISWAP_BUS_LOCK_EN
    logic        mem_lock;
`endif

    // master: the sequencer itself (it masters the data bus)
    modport master (
        input  req_valid, req_instr, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output wb_valid, wb_rd, wb_data, exc_misalign, busy
`ifdef ZISWAP_BUS_LOCK_EN
        , output mem_lock
`endif
    );

    modport slave (
        output req_valid, req_instr, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  wb_valid, wb_rd, wb_data, exc_misalign, busy
`ifdef ZISWAP_BUS_LOCK_EN
        , input mem_lock
`endif
    );
endinterface

// File: rtl/ziswap_seq_ctrl.sv
// rtl/ziswap_seq_ctrl.sv - Ziswap load-then-store sequencer; ZISWAP_BUS_LOCK_EN adds a bus lock held across the RMW
module ziswap_seq_ctrl #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ziswap_seq_ctrl_if.master    bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LD_REQ, S_LD_WAIT, S_ST_REQ, S_ST_WAIT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              hw_q, hw_d;
    logic              sgn_q, sgn_d;
    logic              sel_q, sel_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              exc_q, exc_d;
`ifdef ZISWAP_BUS_LOCK_EN
    logic              lock_q, lock_d;
`endif

    logic [2:0]        funct3;
    logic              is_hw, is_word, bad_req;
    logic [15:0]       hw_sel;
    logic [XLEN-1:0]   ld_ext;
    logic              unused_instr_bits;

    assign funct3            = bus.req_instr[14:12];
    assign is_hw             = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign is_word           = (funct3 == 3'b010);
    assign bad_req           = !(is_hw || is_word) || (is_hw && bus.req_addr[0])
                               || (is_word && (bus.req_addr[1:0] != 2'b00));
    assign unused_instr_bits = ^{bus.req_instr[31:15], bus.req_instr[6:0]};

    assign hw_sel = sel_q ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    assign ld_ext = !hw_q ? bus.mem_rdata
                  : (sgn_q ? {{16{hw_sel[15]}}, hw_sel} : {16'h0000, hw_sel});

    always_comb begin
        state_d     = state_q;
        hw_d        = hw_q;
        sgn_d       = sgn_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        exc_d       = 1'b0;
`ifdef ZISWAP_BUS_LOCK_EN
        lock_d      = lock_q;
`endif
        case (state_q)
            S_IDLE: if (bus.req_valid) begin
                wb_rd_d = bus.req_instr[11:7];
                if (bad_req) begin
                    state_d = S_DONE;
                    exc_d   = 1'b1;
                end else begin
                    state_d    = S_LD_REQ;
                    hw_d       = is_hw;
                    sgn_d      = (funct3 == 3'b001);
                    sel_d      = bus.req_addr[1];
                    wdata_d    = bus.req_wdata;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {bus.req_addr[XLEN-1:2], 2'b00};
                    mem_be_d   = is_word ? 4'b1111 : (bus.req_addr[1] ? 4'b1100 : 4'b0011);
`ifdef ZISWAP_BUS_LOCK_EN
                    lock_d     = 1'b1;
`endif
                end
            end
            S_LD_REQ: if (bus.mem_gnt) begin
                state_d   = S_LD_WAIT;
                mem_req_d = 1'b0;
            end
            S_LD_WAIT: if (bus.mem_rvalid) begin
                state_d     = S_ST_REQ;
                wb_data_d   = ld_ext;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_wdata_d = hw_q ? {2{wdata_q[15:0]}} : wdata_q;
            end
            S_ST_REQ: if (bus.mem_gnt) begin
                state_d   = S_ST_WAIT;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
            S_ST_WAIT: if (bus.mem_rvalid) begin
                state_d    = S_DONE;
                wb_valid_d = 1'b1;
`ifdef ZISWAP_BUS_LOCK_EN
                lock_d     = 1'b0;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hw_q        <= 1'b0;
            sgn_q       <= 1'b0;
            sel_q       <= 1'b0;
            wdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= '0;
            exc_q       <= 1'b0;
`ifdef ZISWAP_BUS_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hw_q        <= hw_d;
            sgn_q       <= sgn_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            exc_q       <= exc_d;
`ifdef ZISWAP_BUS_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

    assign bus.req_ready    = (state_q == S_IDLE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_be       = mem_be_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.exc_misalign = exc_q;
`ifdef ZISWAP_BUS_LOCK_EN
    assign bus.mem_lock     = lock_q;
`endif
endmodule

// File: tb/tb_ziswap_seq_ctrl.sv
// tb/tb_ziswap_seq_ctrl.sv - scoreboard bench for ziswap_seq_ctrl with a delay-configurable memory responder
module tb_ziswap_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ziswap_seq_ctrl_if bus ();
    ziswap_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        bit          exc;
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [0:255];
    int          total = 0, bad = 0;
    int          cyc = 0, mreq_cyc = 0;
    int          n_ld = 0, n_st = 0, last_lat = 0, bad_ready = 0;
    int          gnt_dly = 0, rv_dly = 1;
    bit          resp_busy = 0;
    logic [3:0]  last_be;
    logic [31:0] last_wd;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;
    always @(negedge clk) if (bus.mem_req) mreq_cyc++;

    // memory responder: grant after gnt_dly cycles, respond rv_dly cycles after grant
    initial begin : responder
        logic        r_we;
        logic [3:0]  r_be;
        logic [31:0] r_addr, r_wd;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        forever begin
            if (bus.mem_req && rst_n) begin
                resp_busy = 1;
                r_we = bus.mem_we; r_be = bus.mem_be; r_addr = bus.mem_addr; r_wd = bus.mem_wdata;
                for (int i = 0; i < gnt_dly; i++) begin
                    @(negedge clk);
                    check_eq("bus_hold", {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata},
                             {1'b1, r_we, r_be, r_addr, r_wd});
                end
`ifdef ZISWAP_BUS_LOCK_EN
                check_eq("lock_held", bus.mem_lock, 1'b1);
`endif
                bus.mem_gnt = 1'b1;
                @(negedge clk);
                bus.mem_gnt = 1'b0;
                if (r_we) begin
                    n_st++; last_be = r_be; last_wd = r_wd;
                    for (int b = 0; b < 4; b++)
                        if (r_be[b]) mem[r_addr[9:2]][8*b +: 8] = r_wd[8*b +: 8];
                end else begin
                    n_ld++;
                end
                for (int i = 1; i < rv_dly; i++) @(negedge clk);
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = r_we ? 32'h0 : mem[r_addr[9:2]];
                @(negedge clk);
                bus.mem_rvalid = 1'b0;
                resp_busy = 0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // scoreboard consumer
    always @(negedge clk) begin
        if (rst_n && (bus.wb_valid || bus.exc_misalign)) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_wb", {bus.wb_valid, bus.exc_misalign}, 2'b00);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("wb_valid", bus.wb_valid, !e.exc);
                check_eq("exc_misalign", bus.exc_misalign, e.exc);
                if (!e.exc) begin
                    check_eq("wb_rd", bus.wb_rd, e.rd);
                    check_eq("wb_data", bus.wb_data, e.data);
                end
                last_lat = cyc - e.cyc;
            end
        end
    end

    task automatic check_reset(input string tag);
        check_eq({tag, "_ctl"}, {bus.mem_req, bus.mem_we, bus.wb_valid, bus.exc_misalign, bus.busy, bus.mem_be, bus.wb_rd},
                 {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0});
        check_eq({tag, "_rdy"}, bus.req_ready, 1'b1);
        check_eq({tag, "_data"}, {bus.mem_addr, bus.mem_wdata, bus.wb_data}, 96'h0);
    endtask

    task automatic do_swap(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [31:0] wd, input bit exc);
        exp_t        e;
        int          n;
        logic [31:0] word;
        logic [15:0] hw;
        bus.req_instr = {17'h0, f3, rd, 7'b1101011};
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        word = mem[addr[9:2]];
        hw   = addr[1] ? word[31:16] : word[15:0];
        e.exc = exc; e.rd = rd; e.cyc = cyc;
        e.data = (f3 == 3'b010) ? word : (f3 == 3'b001) ? {{16{hw[15]}}, hw} : {16'h0, hw};
        exp_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bad_ready = 0;
        n = 0;
        while (bus.busy && n < 100) begin
            if (bus.req_ready) bad_ready++;
            @(negedge clk);
            n++;
        end
        check_eq("done_in_time", n < 100, 1'b1);
    endtask

    initial begin : main
        int n, m0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_instr = '0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        mem[64] = 32'h12345678;
        do_swap(3'b010, 5'd5, 32'h100, 32'hCAFEBABE, 0);
        check_eq("lw_latency", last_lat, 5);
        check_eq("lw_be", last_be, 4'b1111);
        check_eq("lw_wdata", last_wd, 32'hCAFEBABE);
        check_eq("lw_mem", mem[64], 32'hCAFEBABE);

        mem[64] = 32'h80010000;
        do_swap(3'b001, 5'd7, 32'h102, 32'h0000AAAA, 0);
        check_eq("lh_be", last_be, 4'b1100);
        check_eq("lh_wdata", last_wd, 32'hAAAAAAAA);
        check_eq("lh_mem", mem[64], 32'hAAAA0000);

        mem[64] = 32'h80010000;
        do_swap(3'b101, 5'd8, 32'h102, 32'h0000AAAA, 0);
        check_eq("lhu_mem", mem[64], 32'hAAAA0000);

        mem[65] = 32'h1234F00D;
        do_swap(3'b001, 5'd9, 32'h104, 32'h99995555, 0);
        check_eq("lh_lo_be", last_be, 4'b0011);
        check_eq("lh_lo_mem", mem[65], 32'h12345555);

        m0 = mreq_cyc + n_ld + n_st;
        do_swap(3'b010, 5'd3, 32'h102, 32'h11111111, 1);
        do_swap(3'b001, 5'd3, 32'h101, 32'h11111111, 1);
        do_swap(3'b011, 5'd3, 32'h100, 32'h11111111, 1);
        check_eq("exc_no_bus", mreq_cyc + n_ld + n_st, m0);
        check_eq("exc_idle", {bus.busy, bus.req_ready}, 2'b01);

        gnt_dly = 3; rv_dly = 2;
        mem[128] = 32'hDEADBEEF;
        m0 = n_ld + 2 * n_st;
        n = n_st;
        do_swap(3'b010, 5'd0, 32'h200, 32'h0BADF00D, 0);
        check_eq("dly_loads", n_ld + 2 * n_st, m0 + 3);
        check_eq("dly_stores", n_st, n + 1);
        check_eq("dly_ready_low", bad_ready, 0);
        check_eq("dly_mem", mem[128], 32'h0BADF00D);

        gnt_dly = 0; rv_dly = 4;
        bus.req_instr = {17'h0, 3'b010, 5'd4, 7'b1101011};
        bus.req_addr  = 32'h100; bus.req_wdata = 32'h55555555; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_ldwait", {bus.busy, bus.mem_req}, 2'b10);
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        n = 0;
        while (resp_busy && n < 20) begin @(negedge clk); n++; end
        check_eq("resp_drain", n < 20, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        rv_dly = 1;
        mem[66] = 32'h00C0FFEE;
        do_swap(3'b010, 5'd12, 32'h108, 32'h76543210, 0);
        check_eq("post_rst_mem", mem[66], 32'h76543210);
        check_eq("cpu_mem_untouched", mem[64], 32'hAAAA0000);
        check_eq("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1);
    end
endmodule
